// File: rtl/audio_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_stream_pkg
// Description : Shared definitions for the audio stream controller: register
//               indices, CTRL/STATUS bit positions, sequencer state encoding
//               and the optional volume scaling helper.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_stream_pkg;

    // Register map (bus address index)
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_DATA      = 3'd2;
    localparam logic [2:0] REG_RELOAD    = 3'd3;
    localparam logic [2:0] REG_THRESHOLD = 3'd4;
    localparam logic [2:0] REG_UNDERRUN  = 3'd5;
    localparam logic [2:0] REG_VOLUME    = 3'd6;
    localparam logic [2:0] REG_RESERVED  = 3'd7;

    // CTRL bits
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    // STATUS bits (fill level occupies [15:0])
    localparam int STATUS_EMPTY_BIT    = 16;
    localparam int STATUS_FULL_BIT     = 17;
    localparam int STATUS_UNDERRUN_BIT = 18;
    localparam int STATUS_OVERFLOW_BIT = 19;

    // Sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STARVED = 2'd2;

    // (sample * (volume + 1)) >>> 8, signed. The magnitude never exceeds 2^23,
    // so a 26-bit product is exact and bits [23:8] are the shifted result.
    function automatic logic [15:0] scale_sample(input logic [15:0] sample,
                                                 input logic [7:0]  volume);
        logic signed [25:0] a;
        logic signed [25:0] b;
        logic signed [25:0] product;
        a       = {{10{sample[15]}}, sample};
        b       = {18'd0, volume} + 26'd1;
        product = a * b;
        return product[23:8];
    endfunction

endpackage : audio_stream_pkg
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_fifo
// Description : Single-clock sample FIFO with push, pop and flush. Flush wins
//               over push/pop; a push into a full FIFO succeeds only when a
//               pop happens in the same cycle.
// Ports       : clk, rst (async, active-high)
//               push, push_data  - write side
//               pop, head        - read side (head is the current oldest entry)
//               flush            - empty the FIFO
//               level, empty, full - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Level never exceeds DEPTH, so its MSB alone marks "full".
    assign empty = (r_level == '0);
    assign full  = r_level[DEPTH_LOG2];
    assign level = r_level;
    assign head  = r_mem[r_rd_ptr];

    assign w_do_pop  = pop  & ~flush & ~empty;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule : audio_sample_fifo
`default_nettype wire

// File: rtl/audio_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : audio_stream_controller
// Description : Bus-mapped sequencer for the PWM audio stage. Buffers samples
//               written by the CPU, hands one sample to the PWM stage per
//               consume strobe (i_pwm_busy low), owns the reload register and
//               raises a level low-watermark interrupt.
// Ports       : i_clock, i_reset (async, active-high)
//               i_request/i_rw/i_address/i_wdata -> o_rdata/o_ready : bus
//               o_interrupt : enable & (level <= THRESHOLD), registered
//               o_sample, o_reload : to PWM stage; i_pwm_busy : consume strobe
// Options     : AUDIO_STREAM_VOLUME_EN - adds VOLUME register (index 6) and a
//               scaling pipeline stage in front of o_sample.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_stream_controller
    import audio_stream_pkg::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = 6,
    parameter logic [31:0] DEFAULT_RELOAD  = 32'd2268
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [2:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_interrupt,
    output logic [15:0] o_sample,
    output logic [31:0] o_reload,
    input  logic        i_pwm_busy
);

    // Registered state
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_interrupt;
    logic [15:0] r_sample;
    logic [31:0] r_reload;
    logic        r_enable;
    logic [15:0] r_threshold;
    logic [31:0] r_underrun_cnt;
    logic        r_underrun_sticky;
    logic        r_overflow_sticky;
    logic [1:0]  r_state;

    // Bus decode
    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_data_wr;
    logic        w_reload_wr;
    logic        w_thresh_wr;
    logic        w_underrun_wr;
    logic        w_status_rd;
    logic [31:0] w_read_value;
    logic [31:0] w_volume_rd;

    // FIFO / sequencer
    logic                     w_flush;
    logic                     w_consume;
    logic                     w_pop;
    logic                     w_underrun;
    logic                     w_overflow;
    logic [15:0]              w_head;
    logic [FIFO_DEPTH_LOG2:0] w_level;
    logic [15:0]              w_level_ext;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_load;
    logic [15:0]              w_next_sample;

    assign o_rdata     = r_rdata;
    assign o_ready     = r_ready;
    assign o_interrupt = r_interrupt;
    assign o_sample    = r_sample;
    assign o_reload    = r_reload;

    // An access is taken on the first cycle the request is seen; the ready
    // cycle itself never starts a second access.
    assign w_accept      = i_request & ~r_ready;
    assign w_wr          = w_accept &  i_rw;
    assign w_rd          = w_accept & ~i_rw;
    assign w_ctrl_wr     = w_wr && (i_address == REG_CTRL);
    assign w_data_wr     = w_wr && (i_address == REG_DATA);
    assign w_reload_wr   = w_wr && (i_address == REG_RELOAD);
    assign w_thresh_wr   = w_wr && (i_address == REG_THRESHOLD);
    assign w_underrun_wr = w_wr && (i_address == REG_UNDERRUN);
    assign w_status_rd   = w_rd && (i_address == REG_STATUS);

    assign w_flush     = w_ctrl_wr & i_wdata[CTRL_FLUSH_BIT];
    assign w_level_ext = 16'(w_level);

    // Consume strobes only count while enabled and streaming.
    assign w_consume  = ~i_pwm_busy & r_enable &
                        ((r_state == ST_RUN) | (r_state == ST_STARVED));
    assign w_pop      = w_consume & ~w_empty & ~w_flush;
    assign w_underrun = w_consume &  w_empty;
    assign w_overflow = w_data_wr &  w_full & ~w_pop;

    audio_sample_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (16)
    ) u_fifo (
        .clk       (i_clock),
        .rst       (i_reset),
        .push      (w_data_wr),
        .push_data (i_wdata[15:0]),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .level     (w_level),
        .empty     (w_empty),
        .full      (w_full)
    );

    always_comb begin
        w_read_value = 32'd0;
        case (i_address)
            REG_CTRL:      w_read_value = {31'd0, r_enable};
            REG_STATUS: begin
                w_read_value[15:0]                = w_level_ext;
                w_read_value[STATUS_EMPTY_BIT]    = w_empty;
                w_read_value[STATUS_FULL_BIT]     = w_full;
                w_read_value[STATUS_UNDERRUN_BIT] = r_underrun_sticky;
                w_read_value[STATUS_OVERFLOW_BIT] = r_overflow_sticky;
            end
            REG_RELOAD:    w_read_value = r_reload;
            REG_THRESHOLD: w_read_value = {16'd0, r_threshold};
            REG_UNDERRUN:  w_read_value = r_underrun_cnt;
            REG_VOLUME:    w_read_value = w_volume_rd;
            default:       w_read_value = 32'd0;
        endcase
    end

    // Value headed for o_sample this cycle (before any volume stage).
    always_comb begin
        w_load        = 1'b0;
        w_next_sample = 16'd0;
        if (!r_enable) begin
            w_load = 1'b1;
        end else if (w_pop) begin
            w_load        = 1'b1;
            w_next_sample = w_head;
        end else if (w_underrun) begin
            w_load = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdata           <= 32'd0;
            r_ready           <= 1'b0;
            r_interrupt       <= 1'b0;
            r_reload          <= DEFAULT_RELOAD;
            r_enable          <= 1'b0;
            r_threshold       <= 16'd0;
            r_underrun_cnt    <= 32'd0;
            r_underrun_sticky <= 1'b0;
            r_overflow_sticky <= 1'b0;
            r_state           <= ST_IDLE;
        end else begin
            r_ready <= w_accept;
            if (w_accept) r_rdata <= w_rd ? w_read_value : 32'd0;

            if (w_ctrl_wr)   r_enable    <= i_wdata[CTRL_ENABLE_BIT];
            if (w_reload_wr) r_reload    <= i_wdata;
            if (w_thresh_wr) r_threshold <= i_wdata[15:0];

            if (w_underrun_wr)
                r_underrun_cnt <= 32'd0;
            else if (w_underrun && (r_underrun_cnt != 32'hFFFF_FFFF))
                r_underrun_cnt <= r_underrun_cnt + 32'd1;

            // A new event in the same cycle as the clearing read survives.
            if (w_underrun && (r_state == ST_RUN))
                r_underrun_sticky <= 1'b1;
            else if (w_status_rd)
                r_underrun_sticky <= 1'b0;

            if (w_overflow)
                r_overflow_sticky <= 1'b1;
            else if (w_status_rd)
                r_overflow_sticky <= 1'b0;

            r_interrupt <= r_enable && (w_level_ext <= r_threshold);

            if (!r_enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:    r_state <= ST_RUN;
                    ST_RUN:     if (w_underrun) r_state <= ST_STARVED;
                    ST_STARVED: if (w_pop)      r_state <= ST_RUN;
                    default:    r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef AUDIO_STREAM_VOLUME_EN
    logic [7:0]  r_volume;
    logic        r_pipe_load;
    logic [15:0] r_pipe_sample;

    assign w_volume_rd = {24'd0, r_volume};

    // One extra stage: capture the selected sample, then scale into o_sample.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_volume      <= 8'hFF;
            r_pipe_load   <= 1'b0;
            r_pipe_sample <= 16'd0;
            r_sample      <= 16'd0;
        end else begin
            if (w_wr && (i_address == REG_VOLUME)) r_volume <= i_wdata[7:0];
            r_pipe_load   <= w_load;
            r_pipe_sample <= w_next_sample;
            if (r_pipe_load) r_sample <= scale_sample(r_pipe_sample, r_volume);
        end
    end
`else
    assign w_volume_rd = 32'd0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sample <= 16'd0;
        end else if (w_load) begin
            r_sample <= w_next_sample;
        end
    end
`endif

endmodule : audio_stream_controller
`default_nettype wire
